cam_capture_rx: RTL and testbench

//  Receive side of the camera interface: captures the sensor's parallel output (PCLK, VSYNC, HREF, D[7:0])

---
 rtl/cam_capture_rx.sv | 205 ++++++++++++++++++++
 tb/tb_cam_capture_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_rx.sv
// cam_capture_rx: receive side of the parallel camera interface.
// All sensor inputs are oversampled in the xvclk domain through 2-FF
// synchronizers. Byte pairs are assembled into RGB565 pixels and written out
// as frame-buffer strobes with a linear address. Frame completion, geometry
// errors and a frame counter go back to control/display logic.
//
// Ports
//   xvclk       master clock, must be >= 4x cam_pclk
//   resetb      synchronous reset, active-high
//   enable      capture enable (level); low aborts the current frame
//   cam_pclk    sensor pixel clock (async)
//   cam_vsync   sensor VSYNC, high during vertical blank
//   cam_href    sensor HREF, high during active line bytes
//   cam_d       sensor data byte
//   pix_we      1-cycle pixel write strobe
//   pix_addr    line*H_PIXELS + column, held between strobes
//   pix_data    {first byte, second byte}, held between strobes
//   frame_done  1-cycle pulse at end of a captured frame
//   frame_err   geometry error, coincident with frame_done
//   capturing   high while in ACTIVE
//   frame_cnt   completed-frame counter, wraps mod 256
module cam_capture_rx #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              xvclk,
  input  logic              resetb,
  input  logic              enable,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [15:0]       pix_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              capturing,
  output logic [7:0]        frame_cnt
);

  // Column saturates at H_PIXELS; line saturates at V_LINES+1 so that an
  // over-long frame can never wrap back to a "correct" line count.
  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_LINES + 2);
  localparam logic [CW-1:0]     H_C   = CW'(H_PIXELS);
  localparam logic [LW-1:0]     V_C   = LW'(V_LINES);
  localparam logic [LW-1:0]     V_MAX = LW'(V_LINES + 1);
  localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_FS, ACTIVE} state_t;
  state_t state, state_n;

  // {pclk, vsync, href, d[7:0]}
  logic [10:0] sync1, sync2;
  logic        pclk_d, vsync_d, href_d;
  logic        pclk_s, vsync_s, href_s;
  logic [7:0]  byte_s;
  logic        pclk_rise, href_fall, vsync_rise, vsync_fall;

  logic [CW-1:0]     col, col_n;
  logic [LW-1:0]     line, line_n;
  logic [ADDR_W-1:0] base, base_n;
  logic              phase, phase_n;
  logic [7:0]        hi, hi_n;
  logic              err, err_n;
  logic              we_n, done_n, ferr_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       data_n;
  logic [7:0]        cnt_n;
  logic              active, enter;

  assign {pclk_s, vsync_s, href_s, byte_s} = sync2;

  // Edge detectors use the synchronizer output against a one-cycle delayed
  // copy, so data/href/vsync are always taken from the same stage as the
  // pclk edge decision.
  assign pclk_rise  = pclk_s & ~pclk_d;
  assign href_fall  = href_d & ~href_s;
  assign vsync_rise = vsync_s & ~vsync_d;
  assign vsync_fall = ~vsync_s & vsync_d;

  assign capturing = (state == ACTIVE);
  assign active    = (state == ACTIVE) && enable;
  assign enter     = (state_n == ACTIVE) && (state != ACTIVE);

  always_ff @(posedge xvclk) begin
    if (resetb) begin
      sync1   <= '0;
      sync2   <= '0;
      pclk_d  <= 1'b0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      sync1   <= {cam_pclk, cam_vsync, cam_href, cam_d};
      sync2   <= sync1;
      pclk_d  <= pclk_s;
      vsync_d <= vsync_s;
      href_d  <= href_s;
    end
  end

  always_ff @(posedge xvclk) begin
    if (resetb) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!enable) state_n = IDLE;
    else begin
      case (state)
        IDLE:    state_n = WAIT_VS;
        WAIT_VS: if (vsync_rise) state_n = WAIT_FS;
        WAIT_FS: if (vsync_fall) state_n = ACTIVE;
        ACTIVE:  if (vsync_rise) state_n = WAIT_FS;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    col_n   = col;
    line_n  = line;
    base_n  = base;
    phase_n = phase;
    hi_n    = hi;
    err_n   = err;
    we_n    = 1'b0;
    addr_n  = pix_addr;
    data_n  = pix_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    cnt_n   = frame_cnt;
    if (enter) begin
      col_n   = '0;
      line_n  = '0;
      base_n  = '0;
      phase_n = 1'b0;
      err_n   = 1'b0;
    end else if (active) begin
      if (href_fall) begin
        if (col != H_C || phase || line >= V_C) err_n = 1'b1;
        phase_n = 1'b0;
        col_n   = '0;
        if (line < V_C)    base_n = base + H_A;
        if (line != V_MAX) line_n = line + 1'b1;
      end else if (pclk_rise && href_s) begin
        if (!phase) begin
          hi_n    = byte_s;
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (col < H_C && line < V_C) begin
            we_n   = 1'b1;
            addr_n = base + ADDR_W'(col);
            data_n = {hi, byte_s};
            col_n  = col + 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      // Uses the post-href-fall line/error values so a coincident line end
      // is counted before the geometry check.
      if (vsync_rise) begin
        done_n = 1'b1;
        ferr_n = err_n | (line_n != V_C);
        cnt_n  = frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge xvclk) begin
    if (resetb) begin
      col        <= '0;
      line       <= '0;
      base       <= '0;
      phase      <= 1'b0;
      hi         <= '0;
      err        <= 1'b0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      col        <= col_n;
      line       <= line_n;
      base       <= base_n;
      phase      <= phase_n;
      hi         <= hi_n;
      err        <= err_n;
      pix_we     <= we_n;
      pix_addr   <= addr_n;
      pix_data   <= data_n;
      frame_done <= done_n;
      frame_err  <= ferr_n;
      frame_cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_cam_capture_rx.sv
// Bench for cam_capture_rx with a small 4x2 geometry. Stimulus tasks push the
// expected pixel writes and frame results into queues; a monitor on the
// falling xvclk edge pops and compares whenever the DUT strobes.
module tb_cam_capture_rx;
  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 15;

  logic          xvclk = 1'b0;
  logic          resetb, enable, cam_pclk, cam_vsync, cam_href;
  logic [7:0]    cam_d;
  logic          pix_we, frame_done, frame_err, capturing;
  logic [AW-1:0] pix_addr;
  logic [15:0]   pix_data;
  logic [7:0]    frame_cnt;

  cam_capture_rx #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .xvclk(xvclk), .resetb(resetb), .enable(enable),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .frame_done(frame_done), .frame_err(frame_err),
    .capturing(capturing), .frame_cnt(frame_cnt)
  );

  always #5 xvclk = ~xvclk;

  typedef struct packed {logic [AW-1:0] addr; logic [15:0] data;} pix_t;
  typedef struct packed {logic err; logic [7:0] cnt;} frm_t;

  pix_t pq[$];
  frm_t fq[$];
  int   total = 0;
  int   bad = 0;
  int   ndone = 0;
  logic [7:0] nb;
  logic [7:0] exp_cnt;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  // Scoreboard monitor
  pix_t pe;
  frm_t fe;
  always @(negedge xvclk) begin
    if (pix_we) begin
      total++;
      if (pq.size() == 0) begin
        bad++;
        $display("FAIL pix_unexpected addr=%0h data=%0h", pix_addr, pix_data);
      end else begin
        pe = pq.pop_front();
        if (pix_addr !== pe.addr || pix_data !== pe.data) begin
          bad++;
          $display("FAIL pix got=%0h/%0h exp=%0h/%0h", pix_addr, pix_data, pe.addr, pe.data);
        end
      end
    end
    if (frame_done) begin
      ndone++;
      total++;
      if (fq.size() == 0) begin
        bad++;
        $display("FAIL frame_unexpected err=%0b cnt=%0d", frame_err, frame_cnt);
      end else begin
        fe = fq.pop_front();
        if (frame_err !== fe.err || frame_cnt !== fe.cnt) begin
          bad++;
          $display("FAIL frame got err=%0b cnt=%0d exp err=%0b cnt=%0d",
                   frame_err, frame_cnt, fe.err, fe.cnt);
        end
      end
    end else if (frame_err) begin
      total++;
      bad++;
      $display("FAIL frame_err_without_done got=1 exp=0");
    end
  end

  // One pclk period = 4 xvclk: 2 low (data changes here), 2 high.
  task automatic pclk_byte(input logic [7:0] b, input logic h);
    @(negedge xvclk);
    cam_pclk = 1'b0; cam_d = b; cam_href = h;
    @(negedge xvclk);
    @(negedge xvclk);
    cam_pclk = 1'b1;
    @(negedge xvclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pclk_byte(8'h00, 1'b0);
  endtask

  task automatic send_pixels(input int n, input int line, input int col0, input bit expect_wr);
    logic [7:0] hb, lb;
    int c;
    for (int i = 0; i < n; i++) begin
      hb = nb;
      lb = nb + 8'h22;
      nb = nb + 8'h44;
      c = col0 + i;
      if (expect_wr && c < H && line < V)
        pq.push_back('{addr: AW'(line*H + c), data: {hb, lb}});
      pclk_byte(hb, 1'b1);
      pclk_byte(lb, 1'b1);
    end
  endtask

  task automatic vs_pulse();
    @(negedge xvclk) cam_vsync = 1'b0;
    idle(1);
    @(negedge xvclk) cam_vsync = 1'b1;
    idle(2);
  endtask

  // One frame: vsync fall, lines, then the vsync rise that closes it.
  task automatic frame(input int p0, input int p1, input int p2, input int nl, input bit ferr);
    int np;
    @(negedge xvclk) cam_vsync = 1'b0;
    idle(1);
    nb = 8'h12;
    for (int l = 0; l < nl; l++) begin
      np = (l == 0) ? p0 : (l == 1) ? p1 : p2;
      send_pixels(np, l, 0, 1'b1);
      idle(2);
    end
    chk("capturing_active", {31'd0, capturing}, 32'd1);
    exp_cnt = exp_cnt + 8'd1;
    fq.push_back('{err: ferr, cnt: exp_cnt});
    vs_pulse();
  endtask

  task automatic do_reset();
    resetb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge xvclk);
      cam_pclk  = 1'($urandom);
      cam_vsync = 1'($urandom);
      cam_href  = 1'($urandom);
      cam_d     = 8'($urandom);
    end
  endtask

  initial begin
    int d0;
    enable = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
    exp_cnt = 8'd0;
    nb = 8'h12;

    // 1: reset with random sensor activity
    do_reset();
    chk("rst_pix_we", {31'd0, pix_we}, 32'd0);
    chk("rst_pix_addr", {17'd0, pix_addr}, 32'd0);
    chk("rst_pix_data", {16'd0, pix_data}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_capturing", {31'd0, capturing}, 32'd0);
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    @(negedge xvclk);
    resetb = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
    enable = 1'b1;
    idle(2);
    vs_pulse();

    // 2: clean frame, first pixel 0x1234
    frame(4, 4, 0, 2, 1'b0);
    chk("t2_cnt", {24'd0, frame_cnt}, 32'd1);
    // 3: short second line
    frame(4, 3, 0, 2, 1'b1);
    // 4: long second line plus a surplus third line
    frame(4, 5, 4, 3, 1'b1);

    // 5: enable dropped mid-line after addr 5
    @(negedge xvclk) cam_vsync = 1'b0;
    idle(1);
    nb = 8'h12;
    send_pixels(4, 0, 0, 1'b1);
    idle(2);
    send_pixels(2, 1, 0, 1'b1);
    repeat (6) @(negedge xvclk);
    enable = 1'b0;
    repeat (2) @(negedge xvclk);
    chk("t5_capturing_off", {31'd0, capturing}, 32'd0);
    send_pixels(2, 1, 2, 1'b0);
    idle(2);
    vs_pulse();
    @(negedge xvclk) cam_vsync = 1'b0;
    idle(2);
    enable = 1'b1;
    idle(1);
    send_pixels(4, 0, 0, 1'b0);   // must be ignored: no vsync rise/fall yet
    idle(2);
    vs_pulse();
    frame(4, 4, 0, 2, 1'b0);
    chk("t5_cnt", {24'd0, frame_cnt}, 32'd4);

    // 6: 256 clean frames from reset wrap the counter to 0
    do_reset();
    @(negedge xvclk);
    resetb = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
    exp_cnt = 8'd0;
    d0 = ndone;
    vs_pulse();
    for (int f = 0; f < 256; f++) frame(4, 4, 0, 2, 1'b0);
    repeat (20) @(negedge xvclk);
    chk("t6_cnt_wrap", {24'd0, frame_cnt}, 32'd0);
    chk("t6_done_count", ndone - d0, 32'd256);

    chk("pix_queue_empty", pq.size(), 32'd0);
    chk("frame_queue_empty", fq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
